// File: rtl/johnson_step_sequencer.sv
// Johnson phase stepper: issues a programmed count of forward or reverse steps at a set interval, with pause and abort.
// Latency: the first step comes max(Interval,1) cycles after Start is taken. No backpressure; Start is dropped while Busy.
module johnson_step_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic [CNT_W-1:0] i_steps,
  input  logic [DIV_W-1:0] i_interval,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_phase_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_remaining
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  localparam logic [WIDTH-2:0] TRANS_ONE = 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_phase;
  logic [WIDTH-1:0] w_phase_step;
  logic [WIDTH-2:0] w_trans;
  logic [CNT_W-1:0] r_remaining;
  logic [DIV_W-1:0] r_presc;
  logic [DIV_W-1:0] w_presc_nxt;
  logic [DIV_W-1:0] w_term;
  logic             r_dir;
  logic             w_tick;
  logic             w_legal;
  logic             w_load;
  logic             w_step;
  logic             w_clear;

  // The >= compare makes a shortened Interval fire on the very next edge.
  assign w_term = (i_interval == '0) ? DIV_W'(1) : i_interval;
  assign w_tick = (r_presc >= (w_term - DIV_W'(1)));

  // A legal Johnson word has at most one boundary between adjacent bits.
  assign w_trans = r_phase[WIDTH-2:0] ^ r_phase[WIDTH-1:1];
  assign w_legal = ((w_trans & (w_trans - TRANS_ONE)) == '0);

  always_comb begin
    w_phase_step = '0;
    if (w_legal) begin
      if (r_dir) w_phase_step = {~r_phase[0], r_phase[WIDTH-1:1]};
      else       w_phase_step = {r_phase[WIDTH-2:0], ~r_phase[WIDTH-1]};
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_clear     = 1'b0;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          w_state_nxt = S_IDLE;
          if (i_start) begin
            if (i_steps != '0) begin
              w_state_nxt = S_RUN;
              w_load      = 1'b1;
              w_presc_nxt = '0;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_RUN: begin
          if (i_pause) begin
            w_state_nxt = S_PAUSED;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            w_step      = 1'b1;
            if (r_remaining == CNT_W'(1)) w_state_nxt = S_DONE;
          end else begin
            w_presc_nxt = r_presc + DIV_W'(1);
          end
        end
        S_PAUSED: begin
          if (!i_pause) w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_phase     <= '0;
      r_remaining <= '0;
      r_presc     <= '0;
      r_dir       <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      if (w_clear) begin
        r_remaining <= '0;
      end else if (w_load) begin
        r_remaining <= i_steps;
        r_dir       <= i_dir;
      end else if (w_step) begin
        r_remaining <= r_remaining - CNT_W'(1);
        r_phase     <= w_phase_step;
      end
    end
  end

  assign o_phase_out = r_phase;
  assign o_remaining = r_remaining;
  assign o_busy      = (r_state == S_RUN) || (r_state == S_PAUSED);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// Scoreboard bench for johnson_step_sequencer: directed runs queue expected phase steps and Done pulses with their cycle numbers.
module tb_johnson_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] steps = '0;
  logic [7:0] interval = 8'd1;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] phase;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  johnson_step_sequencer #(.WIDTH(4), .CNT_W(8), .DIV_W(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_dir(dir),
    .i_steps(steps), .i_interval(interval), .i_pause(pause), .i_abort(abort),
    .o_phase_out(phase), .o_busy(busy), .o_done(done), .o_remaining(remaining)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 = phase step, 1 = done pulse
    logic [3:0] ph;
    int         at;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  logic [3:0] prev_phase = '0;

  task automatic push(input int kind, input logic [3:0] ph, input int at);
    ev_t e;
    e.kind = kind; e.ph = ph; e.at = at;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input logic [3:0] ph);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: kind %0d phase %b at cycle %0d, none expected", kind, ph, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.ph != ph || e.at != cyc) begin
        bad++;
        $display("FAIL event: got kind %0d phase %b cycle %0d, expected kind %0d phase %b cycle %0d",
                 kind, ph, cyc, e.kind, e.ph, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_phase = phase;
    end else begin
      if (phase != prev_phase) begin
        observe(0, phase);
        prev_phase = phase;
      end
      if (done) observe(1, 4'b0000);
    end
  end

  // Called at a falling edge; the run is accepted at edge k.
  task automatic launch(input logic d, input logic [7:0] s, input logic [7:0] iv, output int k);
    dir = d; steps = s; interval = iv; start = 1'b1;
    k = cyc + 1;
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [3:0] fwd_tab[8];
  logic [3:0] t3_tab[7];
  logic [3:0] rev_tab[6];

  initial begin
    int k, r, nbusy;
    fwd_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    t3_tab  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    rev_tab = '{4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_remaining", remaining, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Forward 8 steps, Interval 1
    launch(1'b0, 8'd8, 8'd1, k);
    for (int j = 0; j < 8; j++) push(0, fwd_tab[j], k + 1 + j);
    push(1, 4'b0000, k + 8);
    drop_start();
    nbusy = 0;
    for (int j = 0; j < 12; j++) begin
      if (busy) nbusy++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", nbusy, 8);

    // Reverse 3 steps, Interval 4
    launch(1'b1, 8'd3, 8'd4, k);
    push(0, 4'b1000, k + 4);
    push(0, 4'b1100, k + 8);
    push(0, 4'b1110, k + 12);
    push(1, 4'b0000, k + 12);
    drop_start();
    chk("t2_remaining_start", remaining, 3);
    repeat (13) @(negedge clk);
    chk("t2_remaining_end", remaining, 0);

    // Forward 10 steps, Interval 2, paused after the third step
    launch(1'b0, 8'd10, 8'd2, k);
    push(0, 4'b1100, k + 2);
    push(0, 4'b1000, k + 4);
    push(0, 4'b0000, k + 6);
    drop_start();
    repeat (6) @(negedge clk);
    pause = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_remaining_paused", remaining, 7);
    chk("t3_busy_paused", busy, 1);
    chk("t3_phase_paused", phase, 4'b0000);
    pause = 1'b0;
    r = cyc;
    for (int j = 0; j < 7; j++) push(0, t3_tab[j], r + 3 + 2 * j);
    push(1, 4'b0000, r + 15);
    repeat (17) @(negedge clk);
    chk("t3_remaining_end", remaining, 0);
    chk("t3_busy_end", busy, 0);

    // Reverse 10 steps with an ignored Start and an abort at Remaining 4
    launch(1'b1, 8'd10, 8'd1, k);
    for (int j = 0; j < 6; j++) push(0, rev_tab[j], k + 1 + j);
    drop_start();
    repeat (2) @(negedge clk);
    start = 1'b1; steps = 8'd1; dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("t4_remaining_ignored_start", remaining, 7);
    repeat (3) @(negedge clk);
    chk("t4_remaining_at_abort", remaining, 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy_after_abort", busy, 0);
    chk("t4_remaining_after_abort", remaining, 0);
    chk("t4_phase_held", phase, 4'b0001);
    repeat (4) @(negedge clk);

    // Steps = 0: immediate Done, never Busy
    launch(1'b0, 8'd0, 8'd1, k);
    push(1, 4'b0000, k);
    drop_start();
    chk("t5_busy", busy, 0);
    repeat (2) @(negedge clk);

    // Interval = 0 behaves as 1
    launch(1'b0, 8'd2, 8'd0, k);
    push(0, 4'b0011, k + 1);
    push(0, 4'b0111, k + 2);
    push(1, 4'b0000, k + 2);
    drop_start();
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of a run
    launch(1'b0, 8'd5, 8'd3, k);
    push(0, 4'b1111, k + 3);
    drop_start();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_phase_in_reset", phase, 0);
    chk("t7_busy_in_reset", busy, 0);
    chk("t7_done_in_reset", done, 0);
    chk("t7_remaining_in_reset", remaining, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t7_busy_after_release", busy, 0);
    chk("t7_phase_after_release", phase, 0);
    @(negedge clk);

    // Interval shortened below the running prescaler count
    launch(1'b0, 8'd1, 8'd8, k);
    push(0, 4'b0001, k + 6);
    push(1, 4'b0000, k + 6);
    drop_start();
    repeat (5) @(negedge clk);
    interval = 8'd3;
    repeat (3) @(negedge clk);
    chk("t8_remaining_end", remaining, 0);

    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
